// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - EX-stage to multiply/divide sequencer handshake and result bus
interface muldiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_div;
    logic             hassign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_div, hassign, a, b, flush,
        input  stall, done, hi, lo
    );

    modport slave (
        input  start, is_div, hassign, a, b, flush,
        output stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DIV0,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t           state;
    logic [WIDTH-1:0] acc;      // product upper half / partial remainder
    logic [WIDTH-1:0] mreg;     // multiplier then product lower half / dividend then quotient
    logic [WIDTH-1:0] opnd;     // multiplicand / divisor magnitude
    logic [CNT_W-1:0] cnt;
    logic             div_r;
    logic             neg_q;
    logic             neg_r;
    logic             done_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   acc_step;
    logic [WIDTH-1:0]   mreg_step;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fixed;

    assign mag_a = (bus.hassign && bus.a[WIDTH-1]) ? neg_w(bus.a) : bus.a;
    assign mag_b = (bus.hassign && bus.b[WIDTH-1]) ? neg_w(bus.b) : bus.b;

    assign prod       = {acc, mreg};
    assign prod_fixed = neg_q ? neg_2w(prod) : prod;

    assign bus.stall = ((state == S_IDLE) && bus.start && !bus.flush)
                     || (state == S_CALC) || (state == S_FIX) || (state == S_DIV0);
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

    // One engine iteration: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        addend    = mreg[0] ? opnd : '0;
        mul_sum   = {1'b0, acc} + {1'b0, addend};
        div_shift = {acc, mreg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        acc_step  = '0;
        mreg_step = '0;
        if (div_r) begin
            if (!div_diff[WIDTH]) begin
                acc_step  = div_diff[WIDTH-1:0];
                mreg_step = {mreg[WIDTH-2:0], 1'b1};
            end else begin
                acc_step  = div_shift[WIDTH-1:0];
                mreg_step = {mreg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step  = mul_sum[WIDTH:1];
            mreg_step = {mul_sum[0], mreg[WIDTH-1:1]};
        end
    end

    // Sequencer FSM with registered HI/LO and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            mreg   <= '0;
            opnd   <= '0;
            cnt    <= '0;
            div_r  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done_r <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.flush) begin
                        div_r <= bus.is_div;
                        neg_q <= bus.hassign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        neg_r <= bus.hassign & bus.a[WIDTH-1];
                        acc   <= '0;
                        cnt   <= '0;
                        if (bus.is_div && (bus.b == '0)) begin
                            // raw dividend is parked in mreg so DIV0 can return it in HI
                            mreg  <= bus.a;
                            opnd  <= '0;
                            state <= S_DIV0;
                        end else begin
                            mreg  <= bus.is_div ? mag_a : mag_b;
                            opnd  <= bus.is_div ? mag_b : mag_a;
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc  <= acc_step;
                        mreg <= mreg_step;
                        cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt == LAST_ITER) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        if (div_r) begin
                            lo_r <= neg_q ? neg_w(mreg) : mreg;
                            hi_r <= neg_r ? neg_w(acc) : acc;
                        end else begin
                            hi_r <= prod_fixed[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fixed[WIDTH-1:0];
                        end
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DIV0: begin
                    if (bus.flush) begin
                        state <= S_IDLE;
                    end else begin
                        hi_r   <= mreg;
                        lo_r   <= '1;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl against an arithmetic reference model
module tb_muldiv_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // free-running cycle index used for latency checks
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_ctrl_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           nchecks = 0;
    int           nerrors = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero
    function automatic logic [63:0] ref_model(input logic d, input logic s,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sbv, q, r;
        logic [63:0] p;
        if (!d) begin
            if (s) p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else   p = {32'b0, a} * {32'b0, b};
            return p;
        end
        if (b == '0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
            q   = sa / sbv;
            r   = sa % sbv;
            p   = {r[31:0], q[31:0]};
            return p;
        end
        p = {a % b, a / b};
        return p;
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                nchecks++;
                nerrors++;
                $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("done_hi", bus.hi, mon_e.hi);
                check("done_lo", bus.lo, mon_e.lo);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic d, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int t0, output int lat);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.is_div  = d;
        bus.hassign = s;
        bus.a       = a;
        bus.b       = b;
        t0  = cyc;
        lat = (d && b == '0) ? 2 : W + 2;
        #1;
        check("stall_issue", bus.stall, 1);
    endtask

    task automatic op(input logic d, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit toggle);
        int t0, lat, nstall;
        bit seen;
        logic [63:0] r;
        r = ref_model(d, s, a, b);
        issue(d, s, a, b, t0, lat);
        sb.push_back('{r[63:32], r[31:0], t0 + lat});
        nstall = 1;
        seen   = 1'b0;
        for (int i = 0; i < lat + 10 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen      = 1'b1;
                bus.start = 1'b0;
                check("stall_in_done", bus.stall, 0);
            end else begin
                if (bus.stall) nstall++;
                if (toggle) begin
                    bus.start   = 1'($urandom_range(0, 1));
                    bus.is_div  = 1'($urandom_range(0, 1));
                    bus.hassign = 1'($urandom_range(0, 1));
                    bus.a       = $urandom;
                    bus.b       = $urandom;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        if (!seen) begin
            nchecks++;
            nerrors++;
            $display("FAIL done_timeout: got no done required done by cycle %0d", t0 + lat);
            sb.delete();
            bus.start = 1'b0;
        end
        check("stall_cycles", nstall, lat);
        model_hi = r[63:32];
        model_lo = r[31:0];
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0;
            3:       return 32'h1;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int t0, lat;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.is_div  = 1'b0;
        bus.hassign = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.flush   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_done", bus.done, 0);
        check("reset_stall", bus.stall, 0);
        rst = 1'b0;

        op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
        op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        op(1'b1, 1'b0, 32'd7, 32'd2, 1'b0);
        op(1'b1, 1'b1, 32'h1234_5678, 32'd0, 1'b0);
        op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        op(1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
        op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);

        // flush aborts an in-flight multiply; HI/LO hold (1,2)
        op(1'b1, 1'b0, 32'd5, 32'd2, 1'b0);
        issue(1'b0, 1'b0, 32'd3, 32'd4, t0, lat);
        while (cyc < t0 + 10) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_stall", bus.stall, 0);
        check("flush_hi", bus.hi, model_hi);
        check("flush_lo", bus.lo, model_lo);
        repeat (40) @(negedge clk);
        check("flush_hold_hi", bus.hi, 32'd1);
        check("flush_hold_lo", bus.lo, 32'd2);

        // operands and start churn during CALC must not disturb the latched op
        op(1'b0, 1'b0, 32'd3, 32'd4, 1'b1);

        // reset in the middle of a divide
        issue(1'b1, 1'b1, 32'h7654_3210, 32'd9, t0, lat);
        while (cyc < t0 + 15) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_done", bus.done, 0);
        rst = 1'b0;
        model_hi = '0;
        model_lo = '0;
        op(1'b0, 1'b1, 32'd6, 32'd7, 1'b0);

        repeat (30) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick(), pick(),
               1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
